// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared register-bank constants, dump FSM states and one-hot check
package mips_pkg;

  localparam int NREGS  = 16;
  localparam int REG_AW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } dump_state_t;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  function automatic logic onehot16_ok(input logic [NREGS-1:0] sel);
    return (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/reg_dump_seq.sv
// rtl/reg_dump_seq.sv - handshaked sequencer walking register indices 0..15 for a dump
module reg_dump_seq
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dump_req,
  input  logic              dump_ready,
  output logic [REG_AW-1:0] dump_idx,
  output logic              dump_valid,
  output logic              dump_busy,
  output logic              dump_done
);

  dump_state_t       state;
  logic [REG_AW-1:0] idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dump_req) begin
            state <= SEND;
            idx   <= '0;
          end
        end
        SEND: begin
          if (dump_ready) begin
            if (idx == REG_AW'(NREGS - 1)) begin
              state <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          // Park on index 0 so idle outputs match the reset view.
          state <= IDLE;
          idx   <= '0;
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  assign dump_idx   = idx;
  assign dump_valid = (state == SEND);
  assign dump_busy  = (state == SEND) || (state == DONE);
  assign dump_done  = (state == DONE);

endmodule

// File: rtl/reg_bank16.sv
// rtl/reg_bank16.sv - 16x32 register bank, one-hot write select, bypass, error flag, dump port
module reg_bank16
  import mips_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [NREGS-1:0]  wr_sel,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [REG_AW-1:0] rd_addr_a,
  input  logic [REG_AW-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic              wr_err,
  input  logic              err_clr,
  input  logic              dump_req,
  output logic              dump_busy,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [REG_AW-1:0] dump_idx,
  output logic [WIDTH-1:0]  dump_data,
  output logic              dump_done
);

  logic [WIDTH-1:0] mem [NREGS];
  logic             sel_ok;
  logic             wr_legal;
  logic             wr_illegal;

  assign sel_ok     = onehot16_ok(wr_sel);
  assign wr_legal   = wr_en && sel_ok;
  assign wr_illegal = wr_en && !sel_ok;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (wr_legal && wr_sel[i]) mem[i] <= wr_data;
      end
    end
  end

  // A new illegal write outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err <= 1'b0;
    end else if (wr_illegal) begin
      wr_err <= 1'b1;
    end else if (err_clr) begin
      wr_err <= 1'b0;
    end
  end

  always_comb begin
    rd_data_a = '0;
    if (rd_addr_a != '0) begin
      if (BYPASS && wr_legal && wr_sel[rd_addr_a]) rd_data_a = wr_data;
      else                                          rd_data_a = mem[rd_addr_a];
    end
  end

  always_comb begin
    rd_data_b = '0;
    if (rd_addr_b != '0) begin
      if (BYPASS && wr_legal && wr_sel[rd_addr_b]) rd_data_b = wr_data;
      else                                          rd_data_b = mem[rd_addr_b];
    end
  end

  reg_dump_seq u_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .dump_req   (dump_req),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_valid (dump_valid),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

  assign dump_data = mem[dump_idx];

endmodule
